// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// UART program loader for the single-cycle core's instruction memory.
// Receives a framed image (A5, LEN_LO, LEN_HI, LEN x 4 data bytes, CSUM) on an
// 8N1 serial line and writes little-endian 32-bit words into instruction
// memory. The core is held in reset until the image is accepted.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   defined   : the CSUM byte must equal the XOR of LEN_LO, LEN_HI and all
//               data bytes, otherwise the load ends in ERROR.
//   undefined : the CSUM byte is consumed but ignored; the load ends in DONE.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 4)
//   ADDR_W        instruction-memory word-address width (capacity 2^ADDR_W)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   rx          UART receive line, idle high, asynchronous to clk
//   imem_addr   word address for the instruction-memory write port
//   imem_data   word to write
//   imem_wren   single-cycle write strobe
//   core_rst_n  active-low core reset, released only when the load is done
//   done        image loaded and accepted
//   error       load failed (sticky until rst)
// -----------------------------------------------------------------------------
module boot_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              imem_wren,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // Largest legal LEN is the full memory capacity.
  localparam logic [16:0]     MAX_LEN = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] WRD_ONE = (ADDR_W + 1)'(1);

  // Receiver states
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // Frame states
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // ---------------------------------------------------------------------------
  // Synchroniser and start-edge history
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Line idles high; resetting to 1 avoids a false start edge.
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // UART byte receiver
  // ---------------------------------------------------------------------------
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    rx_state_d   = rx_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = '0;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // Start bit must still be low at its centre, else it was a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin  // RX_STOP
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_valid_d = 1'b1;
          else           frame_err_d  = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser and word assembler
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_words_q, len_words_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [23:0]       asm_q, asm_d;      // lanes 0..2; lane 3 goes straight out
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              wren_q, wren_d;
  logic [15:0]       len_full;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // shift_q holds the byte for the whole cycle byte_valid_q is high.
  assign len_full = {shift_q, len_lo_q};

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_words_d = len_words_q;
    cnt_d       = cnt_q;
    lane_d      = lane_q;
    asm_d       = asm_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wren_d      = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (frame_err_q && state_q != S_DONE && state_q != S_ERROR) begin
      state_d = S_ERROR;
    end else if (byte_valid_q) begin
      case (state_q)
        S_IDLE: begin
          if (shift_q == 8'hA5) state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_lo_d = shift_q;
          state_d  = S_LEN_HI;
`ifdef BOOT_CHECKSUM_EN
          csum_d   = csum_q ^ shift_q;
`endif
        end
        S_LEN_HI: begin
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ shift_q;
`endif
          // Bounding LEN here is what guarantees imem_addr never wraps.
          if ({1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERROR;
          end else begin
            len_words_d = len_full[ADDR_W:0];
            cnt_d       = '0;
            lane_d      = '0;
            state_d     = (len_full == 16'd0) ? S_CSUM : S_DATA;
          end
        end
        S_DATA: begin
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q ^ shift_q;
`endif
          case (lane_q)
            2'd0: asm_d[7:0]   = shift_q;
            2'd1: asm_d[15:8]  = shift_q;
            2'd2: asm_d[23:16] = shift_q;
            default: begin
              data_d = {shift_q, asm_q};
              addr_d = cnt_q[ADDR_W-1:0];
              wren_d = 1'b1;
              cnt_d  = cnt_q + WRD_ONE;
              if (cnt_q + WRD_ONE == len_words_q) state_d = S_CSUM;
            end
          endcase
          lane_d = lane_q + 2'd1;
        end
        S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
          state_d = (shift_q == csum_q) ? S_DONE : S_ERROR;
`else
          state_d = S_DONE;
`endif
        end
        default: ;  // DONE and ERROR are terminal
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_words_q <= '0;
      cnt_q       <= '0;
      lane_q      <= '0;
      asm_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_words_q <= len_words_d;
      cnt_q       <= cnt_d;
      lane_q      <= lane_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign imem_addr  = addr_q;
  assign imem_data  = data_q;
  assign imem_wren  = wren_q;
  assign done       = (state_q == S_DONE);
  assign core_rst_n = (state_q == S_DONE);  // a failed image never runs
  assign error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_boot_loader.sv
`timescale 1ns/1ps
module tb_boot_loader;

  localparam int CPB = 8;
  localparam int AW  = 4;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_wren;
  logic          core_rst_n;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_wren  (imem_wren),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Write monitor: captures every strobe, cleared by rst.
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          cyc     = 0;
  int          last_wr = -1;
  int          min_gap = 1 << 30;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      got_addr.delete();
      got_data.delete();
      last_wr = -1;
    end else if (imem_wren === 1'b1) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_data);
      if (last_wr >= 0 && cyc - last_wr < min_gap) min_gap = cyc - last_wr;
      last_wr = cyc;
    end
  end

  // Reference model: parse the byte stream by frame layout.
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done, exp_err;

  task automatic model(input logic [7:0] b[$], input int bad);
    int limit, s, len, c;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    limit = (bad >= 0) ? bad : b.size();
    s = -1;
    for (int i = 0; i < limit; i++) begin
      if (b[i] == 8'hA5) begin
        s = i;
        break;
      end
    end
    if (s < 0 || s + 2 >= limit) begin
      exp_err = (bad >= 0);
      return;
    end
    len = int'(b[s+1]) + 256 * int'(b[s+2]);
    if (len > (1 << AW)) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < len; w++) begin
      int p;
      p = s + 3 + 4 * w;
      if (p + 3 >= limit) begin
        exp_err = (bad >= 0);
        return;
      end
      exp_addr.push_back(w);
      exp_data.push_back({b[p+3], b[p+2], b[p+1], b[p]});
    end
    c = s + 3 + 4 * len;
    if (c >= limit) begin
      exp_err = (bad >= 0);
      return;
    end
    x = 8'h00;
    for (int i = s + 1; i < c; i++) x ^= b[i];
    exp_done = !CHK_ON || (b[c] == x);
    exp_err  = !exp_done;
  endtask

  // Serial stimulus, driven on the falling edge.
  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit good_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit(good_stop);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int bad);
    foreach (b[i]) send_byte(b[i], i != bad);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, " done"},       32'(done),       32'(exp_done));
    check({tag, " error"},      32'(error),      32'(exp_err));
    check({tag, " core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
    check({tag, " nwrites"},    32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s data%0d", tag, i), got_data[i], exp_data[i]);
    end
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] b[$], input int bad);
    do_reset();
    send_frame(b, bad);
    repeat (2 * CPB) @(negedge clk);
    model(b, bad);
    compare_outputs(tag);
  endtask

  // Directed vectors: byte stream, bad-stop index, hand-derived outcome.
  typedef struct {
    logic [7:0] b [0:15];
    int         n;
    int         bad;
    bit         d;
    bit         e;
    int         nw;
  } vec_t;

  function automatic vec_t mk(input logic [127:0] raw, input int n, input int bad,
                              input bit d, input bit e, input int nw);
    vec_t v;
    v.n = n; v.bad = bad; v.d = d; v.e = e; v.nw = nw;
    for (int i = 0; i < 16; i++) begin
      if (i < n) v.b[i] = raw[8*(n-1-i) +: 8];
      else       v.b[i] = 8'h00;
    end
    return v;
  endfunction

  vec_t vecs [8];

  initial begin
    logic [7:0] q[$];
    logic [7:0] x, t;
    int len, bad, pre;

    rst = 1'b1;
    rx  = 1'b1;

    vecs[0] = mk(96'hA5_02_00_13_05_10_00_93_00_20_00_B7, 12, -1, 1'b1, 1'b0, 2);
    vecs[1] = mk(96'hA5_02_00_13_05_10_00_93_00_20_00_00, 12, -1, !CHK_ON, CHK_ON, 2);
    vecs[2] = mk(48'h00_FF_A5_00_00_00, 6, -1, 1'b1, 1'b0, 0);
    vecs[3] = mk(24'hA5_11_00, 3, -1, 1'b0, 1'b1, 0);
    vecs[4] = mk(64'hA5_01_00_11_22_33_44_55, 8, 4, 1'b0, 1'b1, 0);
    vecs[5] = mk(40'h00_A5_00_00_00, 5, 0, 1'b0, 1'b1, 0);
    vecs[6] = mk(96'hA5_00_00_00_A5_01_00_DE_AD_BE_EF_00, 12, -1, 1'b1, 1'b0, 0);
    vecs[7] = mk(32'hA5_00_00_5A, 4, -1, !CHK_ON, CHK_ON, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst imem_addr",  32'(imem_addr),  32'h0);
    check("rst imem_data",  imem_data,       32'h0);
    check("rst imem_wren",  32'(imem_wren),  32'h0);
    check("rst core_rst_n", 32'(core_rst_n), 32'h0);
    check("rst done",       32'(done),       32'h0);
    check("rst error",      32'(error),      32'h0);
    rst = 1'b0;

    // Directed table
    for (int v = 0; v < 8; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].b[i]);
      run_and_check($sformatf("vec%0d", v), q, vecs[v].bad);
      check($sformatf("vec%0d tbl done", v),    32'(done),  32'(vecs[v].d));
      check($sformatf("vec%0d tbl error", v),   32'(error), 32'(vecs[v].e));
      check($sformatf("vec%0d tbl nwrites", v), 32'(got_addr.size()), 32'(vecs[v].nw));
    end

    // Start glitch right before a real frame must not disturb it
    do_reset();
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    q.delete();
    q.push_back(8'hA5); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00);
    send_frame(q, -1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch done",  32'(done),  32'h1);
    check("glitch error", 32'(error), 32'h0);

    // Reset in the middle of the data phase, then a full resend
    do_reset();
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(vecs[0].b[i]);
    send_frame(q, -1);
    repeat (2 * CPB) @(negedge clk);
    check("midrst pre nwrites", 32'(got_addr.size()), 32'h1);
    check("midrst pre data",    imem_data, 32'h00100513);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst imem_addr",  32'(imem_addr),  32'h0);
    check("midrst imem_data",  imem_data,       32'h0);
    check("midrst imem_wren",  32'(imem_wren),  32'h0);
    check("midrst core_rst_n", 32'(core_rst_n), 32'h0);
    check("midrst done",       32'(done),       32'h0);
    check("midrst error",      32'(error),      32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(vecs[0].b[i]);
    send_frame(q, -1);
    repeat (2 * CPB) @(negedge clk);
    check("resend nwrites", 32'(got_addr.size()), 32'h2);
    if (got_addr.size() == 2) begin
      check("resend addr0", 32'(got_addr[0]), 32'h0);
      check("resend data0", got_data[0], 32'h00100513);
      check("resend addr1", 32'(got_addr[1]), 32'h1);
      check("resend data1", got_data[1], 32'h00200093);
    end
    check("resend done", 32'(done), 32'h1);

    // Full-capacity image (LEN = 2^ADDR_W)
    q.delete();
    q.push_back(8'hA5); q.push_back(8'(1 << AW)); q.push_back(8'h00);
    x = 8'(1 << AW);
    for (int i = 0; i < 4 * (1 << AW); i++) begin
      t = 8'($urandom);
      q.push_back(t);
      x ^= t;
    end
    q.push_back(x);
    run_and_check("full", q, -1);
    check("full done", 32'(done), 32'h1);

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      q.delete();
      pre = $urandom_range(0, 2);
      for (int i = 0; i < pre; i++) begin
        t = 8'($urandom);
        if (t == 8'hA5) t = 8'h5A;
        q.push_back(t);
      end
      len = $urandom_range(0, 17);
      q.push_back(8'hA5); q.push_back(8'(len)); q.push_back(8'h00);
      x = 8'(len);
      for (int i = 0; i < 4 * len; i++) begin
        t = 8'($urandom);
        q.push_back(t);
        x ^= t;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 + $urandom_range(0, 254));
      q.push_back(x);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, q.size() - 1) : -1;
      run_and_check($sformatf("rand%0d", r), q, bad);
    end

    // Write strobes are at least four byte times apart
    check("wren spacing", 32'(min_gap >= 4 * 10 * CPB), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
